// File: rtl/prng_range_gen.sv
// rtl/prng_range_gen.sv - Fibonacci LFSR random source with bounded-range rejection sampling
// Optional macro PRNG_FREE_RUN_EN: LFSR also steps in IDLE and DONE for request-timing entropy.
module prng_range_gen #(
  parameter int                LFSR_W    = 32,
  parameter int                OUT_W     = 10,
  parameter logic [LFSR_W-1:0] TAPS      = 32'h80200003,
  parameter logic [LFSR_W-1:0] SEED      = 32'hACE1ACE1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OUT_W-1:0]  range_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_fallback
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] lfsr_step;
  logic [OUT_W-1:0]  range_q;
  logic [OUT_W-1:0]  mask;
  logic [OUT_W-1:0]  cand;
  logic [7:0]        tries_q;
  logic              cand_ok;
  logic              last_try;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_fallback_q;

  // A seed load always wins over stepping; a zero seed would lock the LFSR.
  always_comb begin
    lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    lfsr_d    = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (state_q == GEN) begin
      lfsr_d = lfsr_step;
    end
`ifdef PRNG_FREE_RUN_EN
    else begin
      lfsr_d = lfsr_step;
    end
`else
`endif
  end

  // Smallest all-ones mask covering the latched range: bit i set if any range bit >= i is set.
  always_comb begin
    mask = '0;
    for (int i = 0; i < OUT_W; i++) begin
      mask[i] = |(range_q >> i);
    end
  end

  assign cand     = lfsr_q[OUT_W-1:0] & mask;
  assign cand_ok  = (cand <= range_q);
  assign last_try = (({1'b0, tries_q} + 9'd1) == 9'(MAX_TRIES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED;
      range_q        <= '0;
      tries_q        <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_fallback_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            range_q <= range_max;
            tries_q <= '0;
            state_q <= GEN;
          end
        end
        GEN: begin
          tries_q <= tries_q + 8'd1;
          if (cand_ok) begin
            out_data_q     <= cand;
            out_fallback_q <= 1'b0;
            out_valid_q    <= 1'b1;
            state_q        <= DONE;
          end else if (last_try) begin
            // Dropping the top mask bit guarantees a value strictly below the range.
            out_data_q     <= cand & (mask >> 1);
            out_fallback_q <= 1'b1;
            out_valid_q    <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_fallback = out_fallback_q;

endmodule
